lsu_wb_stage: RTL and testbench

- Memory-access/writeback stage sitting between execute and the 8x16-bit register file.
- Accepts one instruction at a time from execute: ALU result, load or store.
- Runs the data-memory handshake.
- Presents a single-cycle write to the register file: write data, destination address, load-select and memory data.
- Stalls execute via ready/valid while a memory access is outstanding.

---
 rtl/lsu_wb_stage_pkg.sv | 24 ++
 rtl/lsu_wb_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_lsu_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_wb_stage_pkg.sv
// Shared types and defaults for the memory-access / writeback stage.
//   op_e    : instruction class from execute (NOP, ALU, LD, ST)
//   state_e : stage FSM states (IDLE, REQ, WAIT, WB)
//   LSU_DW / LSU_AW : default data/address width and register-file address width
package lsu_wb_stage_pkg;

  localparam int LSU_DW = 16;
  localparam int LSU_AW = 3;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ALU = 2'd1,
    OP_LD  = 2'd2,
    OP_ST  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_wb_stage.sv
// Memory-access / writeback stage between execute and an 8x16 register file.
//
// Accepts one instruction at a time from execute, runs the data-memory
// request/response handshake for loads and stores, and presents a registered
// single-cycle write to the register file.
//
// Optional build macro: LSU_TIMEOUT_EN
//   defined   : a 4-bit wait counter aborts an access after TIMEOUT cycles in
//               REQ/WAIT, sets the sticky err flag and returns to IDLE.
//   undefined : no counter, err tied 0, REQ/WAIT wait indefinitely.
//
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   ex_valid/ex_ready     : execute handshake; transfer when both are high.
//                           ex_ready is high only in IDLE and depends only on
//                           state, so execute may hold ex_valid and its payload
//                           until the cycle it is accepted.
//   ex_op/ex_result/ex_sdata/ex_dst : instruction payload
//   mem_req/mem_we/mem_addr/mem_wdata/mem_gnt : memory request channel; request
//                           and its payload are held stable until mem_gnt
//   mem_rvalid/mem_rdata  : memory response (load data or store completion)
//   wb_en/wb_addr/wb_data/wb_is_ld/wb_mem_data : register-file write; payload
//                           holds its value while wb_en is low
//   busy                  : FSM is not in IDLE
//   err                   : sticky timeout flag
//   dbg_state             : current FSM state (state_e encoding)
module lsu_wb_stage
  import lsu_wb_stage_pkg::*;
#(
  parameter int DW      = LSU_DW,
  parameter int AW      = LSU_AW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [1:0]    ex_op,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_sdata,
  input  logic [AW-1:0] ex_dst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          wb_is_ld,
  output logic [DW-1:0] wb_mem_data,
  output logic          busy,
  output logic          err,
  output logic [1:0]    dbg_state
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] addr_q, addr_d;     // ALU result or effective address
  logic [DW-1:0] sdata_q, sdata_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          wb_en_q, wb_en_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          wb_is_ld_q, wb_is_ld_d;
  logic [DW-1:0] wb_mem_data_q, wb_mem_data_d;

  op_e ex_op_e;
  assign ex_op_e = op_e'(ex_op);

`ifdef LSU_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    dst_d   = dst_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          case (ex_op_e)
            OP_ALU: begin
              op_d    = OP_ALU;
              addr_d  = ex_result;
              dst_d   = ex_dst;
              state_d = S_WB;
            end
            OP_LD, OP_ST: begin
              op_d    = ex_op_e;
              addr_d  = ex_result;
              sdata_d = ex_sdata;
              dst_d   = ex_dst;
              state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
              cnt_d   = 4'd0;
`endif
            end
            default: ;  // NOP is accepted and dropped
          endcase
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          // Zero-latency memory may answer in the grant cycle.
          if (mem_rvalid) begin
            if (op_q == OP_LD) begin
              rdata_d = mem_rdata;
              state_d = S_WB;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (op_q == OP_LD) begin
            rdata_d = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;  // S_WB lasts exactly one cycle
    endcase

`ifdef LSU_TIMEOUT_EN
    // Abort only when this cycle would otherwise keep waiting; a response
    // arriving on the last allowed cycle still completes normally.
    if ((state_q == S_REQ || state_q == S_WAIT) &&
        (state_d == S_REQ || state_d == S_WAIT)) begin
      if (cnt_q == 4'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
`endif

    // WB is always left after one cycle, so state_d == S_WB marks entry.
    wb_en_d       = (state_d == S_WB);
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    wb_is_ld_d    = wb_is_ld_q;
    wb_mem_data_d = wb_mem_data_q;
    if (state_d == S_WB) begin
      wb_addr_d     = dst_d;
      wb_data_d     = addr_d;
      wb_is_ld_d    = (op_d == OP_LD);
      wb_mem_data_d = (op_d == OP_LD) ? rdata_d : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      addr_q        <= '0;
      sdata_q       <= '0;
      dst_q         <= '0;
      rdata_q       <= '0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_is_ld_q    <= 1'b0;
      wb_mem_data_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      sdata_q       <= sdata_d;
      dst_q         <= dst_d;
      rdata_q       <= rdata_d;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_is_ld_q    <= wb_is_ld_d;
      wb_mem_data_q <= wb_mem_data_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ex_ready    = (state_q == S_IDLE);
  assign mem_req     = (state_q == S_REQ);
  assign mem_we      = (state_q == S_REQ) && (op_q == OP_ST);
  assign mem_addr    = addr_q;
  assign mem_wdata   = sdata_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign wb_is_ld    = wb_is_ld_q;
  assign wb_mem_data = wb_mem_data_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Testbench for lsu_wb_stage: table of directed instructions with a simple
// memory responder, plus hand-written reset, back-to-back and wait/timeout
// sequences. Build with +define+LSU_TIMEOUT_EN to exercise the watchdog.
module tb_lsu_wb_stage;
  import lsu_wb_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [1:0]  ex_op = 2'd0;
  logic [15:0] ex_result = '0;
  logic [15:0] ex_sdata = '0;
  logic [2:0]  ex_dst = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        wb_en, wb_is_ld, busy, err;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data, wb_mem_data;
  logic [1:0]  dbg_state;

  lsu_wb_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_result(ex_result), .ex_sdata(ex_sdata), .ex_dst(ex_dst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_is_ld(wb_is_ld), .wb_mem_data(wb_mem_data),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [15:0] res;
    logic [15:0] sdata;
    logic [2:0]  dst;
    int          gd;       // REQ cycles before mem_gnt
    int          rd;       // cycles from gnt to rvalid (0 = same cycle)
    logic [15:0] rdata;
    logic        exp_wb;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_is_ld;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int  c;
    bit  done;
    chk("ex_ready_idle", ex_ready, 1);
    ex_valid  = 1'b1;
    ex_op     = v.op;
    ex_result = v.res;
    ex_sdata  = v.sdata;
    ex_dst    = v.dst;
    step();
    // Scramble payload after acceptance: the stage must have latched it.
    ex_valid  = 1'b0;
    ex_op     = 2'd0;
    ex_result = 16'($urandom);
    ex_sdata  = 16'($urandom);
    ex_dst    = 3'($urandom);
    if (v.op != OP_ALU) begin
      c = 0;
      done = 1'b0;
      while (!done && c < 40) begin
        mem_gnt    = (c == v.gd);
        mem_rvalid = (c == v.gd + v.rd);
        mem_rdata  = mem_rvalid ? v.rdata : 16'($urandom);
        chk("mem_req", mem_req, (c <= v.gd));
        if (c <= v.gd) begin
          chk("mem_addr", mem_addr, v.res);
          chk("mem_we", mem_we, (v.op == OP_ST));
          if (v.op == OP_ST) chk("mem_wdata", mem_wdata, v.sdata);
        end
        chk("wb_en_wait", wb_en, 0);
        chk("ex_ready_wait", ex_ready, 0);
        if (c == v.gd + v.rd) done = 1'b1;
        step();
        c++;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!done) begin
        n_vec++;
        n_bad++;
        $display("FAIL mem_budget: got no completion expected completion");
      end
    end
    if (v.exp_wb) begin
      chk("wb_en", wb_en, 1);
      chk("wb_addr", wb_addr, v.exp_addr);
      chk("wb_data", wb_data, v.exp_data);
      chk("wb_is_ld", wb_is_ld, v.exp_is_ld);
      chk("wb_mem_data", wb_mem_data, v.exp_mem);
      chk("ex_ready_wb", ex_ready, 0);
      chk("dbg_state_wb", dbg_state, S_WB);
      step();
      chk("wb_en_drop", wb_en, 0);
      chk("wb_addr_hold", wb_addr, v.exp_addr);
      chk("wb_data_hold", wb_data, v.exp_data);
    end else begin
      chk("wb_en_st", wb_en, 0);
    end
    chk("ex_ready_back", ex_ready, 1);
    chk("busy_back", busy, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{OP_ALU, 16'h1234, 16'h0000, 3'd5, 0, 0, 16'h0000, 1'b1, 3'd5, 16'h1234, 1'b0, 16'h0000};
    vecs[1] = '{OP_ALU, 16'hFFFF, 16'h0000, 3'd0, 0, 0, 16'h0000, 1'b1, 3'd0, 16'hFFFF, 1'b0, 16'h0000};
    vecs[2] = '{OP_LD,  16'h00A0, 16'h0000, 3'd3, 2, 3, 16'hBEEF, 1'b1, 3'd3, 16'h00A0, 1'b1, 16'hBEEF};
    vecs[3] = '{OP_ST,  16'h0010, 16'h5555, 3'd4, 0, 0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{OP_LD,  16'h0008, 16'h0000, 3'd6, 0, 0, 16'h0F0F, 1'b1, 3'd6, 16'h0008, 1'b1, 16'h0F0F};
    vecs[5] = '{OP_ST,  16'hFFFE, 16'hAAAA, 3'd1, 1, 2, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[6] = '{OP_LD,  16'h7777, 16'h0000, 3'd7, 0, 4, 16'h8001, 1'b1, 3'd7, 16'h7777, 1'b1, 16'h8001};
    vecs[7] = '{OP_ALU, 16'h0000, 16'h0000, 3'd2, 0, 0, 16'h0000, 1'b1, 3'd2, 16'h0000, 1'b0, 16'h0000};

    // ---- reset state ----
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_dbg_state", dbg_state, S_IDLE);
    rst = 1'b1;
    step();

    // ---- NOP accepted, no state change ----
    ex_valid = 1'b1;
    ex_op    = OP_NOP;
    step();
    ex_valid = 1'b0;
    chk("nop_busy", busy, 0);
    chk("nop_wb_en", wb_en, 0);

    // ---- table ----
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // ---- back-to-back ALU then zero-latency LD, ex_valid held ----
    mem_gnt    = 1'b1;  // held high: must be ignored outside REQ
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hC0DE;
    ex_valid   = 1'b1;
    ex_op      = OP_ALU;
    ex_result  = 16'h1111;
    ex_dst     = 3'd1;
    step();
    chk("b2b_wb1_en", wb_en, 1);
    chk("b2b_wb1_addr", wb_addr, 1);
    chk("b2b_wb1_data", wb_data, 16'h1111);
    ex_op     = OP_LD;
    ex_result = 16'h2222;
    ex_dst    = 3'd2;
    step();
    chk("b2b_gap_en", wb_en, 0);
    chk("b2b_ready", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    chk("b2b_req", mem_req, 1);
    chk("b2b_req_addr", mem_addr, 16'h2222);
    chk("b2b_req_wb_en", wb_en, 0);
    step();
    chk("b2b_wb2_en", wb_en, 1);
    chk("b2b_wb2_addr", wb_addr, 2);
    chk("b2b_wb2_is_ld", wb_is_ld, 1);
    chk("b2b_wb2_mem", wb_mem_data, 16'hC0DE);
    step();
    chk("b2b_end_en", wb_en, 0);
    chk("b2b_end_busy", busy, 0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;

    // ---- reset while a load waits for data ----
    ex_valid  = 1'b1;
    ex_op     = OP_LD;
    ex_result = 16'h0040;
    ex_dst    = 3'd7;
    step();
    ex_valid = 1'b0;
    mem_gnt  = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rw_wait_state", dbg_state, S_WAIT);
    #2 rst = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_mem_req", mem_req, 0);
    chk("rw_wb_en", wb_en, 0);
    chk("rw_ex_ready", ex_ready, 1);
    step();
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rw_late_wb_en", wb_en, 0);
      chk("rw_late_busy", busy, 0);
    end
    mem_rvalid = 1'b0;

    // ---- load whose grant never comes ----
    ex_valid  = 1'b1;
    ex_op     = OP_LD;
    ex_result = 16'h0300;
    ex_dst    = 3'd4;
    step();
    ex_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    n = 0;
    while (mem_req && n < 40) begin
      chk("to_wb_en", wb_en, 0);
      n++;
      step();
    end
    chk("to_req_cycles", n, 15);
    chk("to_err", err, 1);
    chk("to_ex_ready", ex_ready, 1);
    chk("to_wb_en_end", wb_en, 0);
    step();
    step();
    chk("to_err_sticky", err, 1);
    chk("to_wb_en_after", wb_en, 0);
`else
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req) n++;
      chk("nt_err", err, 0);
      chk("nt_wb_en", wb_en, 0);
      step();
    end
    chk("nt_req_cycles", n, 20);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h4321;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk("nt_wb_en_done", wb_en, 1);
    chk("nt_wb_mem", wb_mem_data, 16'h4321);
    chk("nt_wb_addr", wb_addr, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
